// File: rtl/servant_uart_pkg.sv
// servant_uart_pkg
// Shared definitions for the servant UART blocks: the receiver FSM state
// encoding and the bit positions of the status word that the CPU reads.
// A future servant_uart_tx is expected to import this package as well.
// Optional feature macro: SERVANT_UART_RX_PARITY_EN (PAR state is only
// reachable when it is defined).
package servant_uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } rx_state_t;

  // Status word layout returned on a bus read
  localparam int DATA_LSB = 0;
  localparam int VALID    = 8;
  localparam int OVR      = 9;
  localparam int FERR     = 10;
  localparam int PERR     = 11;

endpackage

// File: rtl/servant_uart_rx_core.sv
// servant_uart_rx_core
// Serial receive engine: 2-FF input synchronizer, baud counter, frame FSM
// and LSB-first shift register. Emits a one-cycle strobe with the received
// byte on a good stop bit, or a one-cycle framing-error pulse on a low stop
// bit (the byte is then discarded and the FSM waits for the line to return
// high before hunting for a new start bit).
// Optional feature macro: SERVANT_UART_RX_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit and the o_perr output.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_rx         serial line (idle high, asynchronous)
//   o_byte_stb   one-cycle strobe, o_byte holds a committed byte
//   o_byte       received byte
//   o_perr       (parity builds) parity error, valid with o_byte_stb
//   o_ferr       one-cycle framing-error pulse
module servant_uart_rx_core
  import servant_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
`ifdef SERVANT_UART_RX_PARITY_EN
  output logic       o_perr,
`endif
  output logic       o_ferr
);

  localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
  // Half a bit lands every later sample in the middle of its bit cell
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    r_sync;
  logic          w_rxs;
  rx_state_t     r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [7:0]    r_shreg, w_shreg_next;
  logic          w_cnt_zero;
`ifdef SERVANT_UART_RX_PARITY_EN
  logic          r_par, w_par_next;
`endif

  assign w_rxs      = r_sync[1];
  assign w_cnt_zero = (r_cnt == '0);
  assign o_byte     = r_shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
`ifdef SERVANT_UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], i_rx};
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
`ifdef SERVANT_UART_RX_PARITY_EN
      r_par     <= w_par_next;
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    o_byte_stb     = 1'b0;
    o_ferr         = 1'b0;
`ifdef SERVANT_UART_RX_PARITY_EN
    w_par_next     = r_par;
    o_perr         = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_rxs) begin
          w_cnt_next   = HALF_RELOAD;
          w_state_next = START;
        end
      end
      START: begin
        if (w_cnt_zero) begin
          if (!w_rxs) begin
            w_cnt_next     = FULL_RELOAD;
            w_bit_idx_next = 3'd0;
            w_state_next   = DATA;
          end else begin
            // Line went back high before mid-start: treat as a glitch
            w_state_next = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      DATA: begin
        if (w_cnt_zero) begin
          w_shreg_next   = {w_rxs, r_shreg[7:1]};
          w_cnt_next     = FULL_RELOAD;
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef SERVANT_UART_RX_PARITY_EN
            w_state_next = PAR;
`else
            w_state_next = STOP;
`endif
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`ifdef SERVANT_UART_RX_PARITY_EN
      PAR: begin
        if (w_cnt_zero) begin
          w_par_next   = w_rxs;
          w_cnt_next   = FULL_RELOAD;
          w_state_next = STOP;
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
`endif
      STOP: begin
        if (w_cnt_zero) begin
          if (w_rxs) begin
            o_byte_stb   = 1'b1;
`ifdef SERVANT_UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to 0
            o_perr       = ^{r_shreg, r_par};
`endif
            w_state_next = IDLE;
          end else begin
            o_ferr       = 1'b1;
            w_state_next = BRK;
          end
        end else begin
          w_cnt_next = r_cnt - CW'(1);
        end
      end
      BRK: begin
        // Hold here so a line stuck low cannot spawn back-to-back frames
        if (w_rxs) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/servant_uart_rx.sv
// servant_uart_rx
// Wishbone-slave UART receiver (8N1, LSB first) for the servant SoC.
// Holds one received byte plus VALID/OVR/FERR/PERR flags for polling.
// Read  : returns {20'b0, perr, ferr, ovr, valid, data[7:0]} and clears valid.
// Write : clears ovr, ferr and perr (write data is ignored).
// Optional feature macro: SERVANT_UART_RX_PARITY_EN (even parity bit, 11-bit
// frame, perr flag); without it perr reads as constant 0.
// Ports:
//   wb_clk, wb_rst_n  clock, asynchronous active-low reset
//   i_rx              serial input, idle high
//   i_wb_cyc          combined cyc/stb request
//   i_wb_we           write enable
//   i_wb_dat          write data (ignored)
//   o_wb_rdt          registered read data
//   o_wb_ack          single-cycle acknowledge
module servant_uart_rx
  import servant_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 139,
  parameter int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        i_rx,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);

  logic        w_byte_stb;
  logic [7:0]  w_byte;
  logic        w_ferr_pulse;
  logic        w_perr_flag;
  logic        w_access;
  logic        w_rd_clr;
  logic        w_wr_clr;
  logic [31:0] w_status;
  logic        w_unused;

  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_ovr;
  logic        r_ferr;
  logic        r_ack;
  logic [31:0] r_rdt;

`ifdef SERVANT_UART_RX_PARITY_EN
  logic        w_perr_pulse;
  logic        r_perr;
`endif

  assign w_unused = ^i_wb_dat;

  servant_uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CW           (CW)
  ) u_core (
    .clk        (wb_clk),
    .rst_n      (wb_rst_n),
    .i_rx       (i_rx),
    .o_byte_stb (w_byte_stb),
    .o_byte     (w_byte),
`ifdef SERVANT_UART_RX_PARITY_EN
    .o_perr     (w_perr_pulse),
`endif
    .o_ferr     (w_ferr_pulse)
  );

  // An access is taken on the cycle the ack is being raised
  assign w_access = i_wb_cyc & ~r_ack;
  assign w_rd_clr = w_access & ~i_wb_we;
  assign w_wr_clr = w_access & i_wb_we;

  always_comb begin
    w_status                    = '0;
    w_status[DATA_LSB +: 8]     = r_data;
    w_status[VALID]             = r_valid;
    w_status[OVR]               = r_ovr;
    w_status[FERR]              = r_ferr;
    w_status[PERR]              = w_perr_flag;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= w_access;
      if (w_access) begin
        r_rdt <= w_status;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      // A commit beats a read-clear: the reader gets the old byte from
      // w_status while the new byte stays pending.
      if (w_byte_stb) begin
        r_data  <= w_byte;
        r_valid <= 1'b1;
      end else if (w_rd_clr) begin
        r_valid <= 1'b0;
      end

      // Flag-clearing write beats any simultaneous set
      if (w_wr_clr) begin
        r_ovr <= 1'b0;
      end else if (w_byte_stb && r_valid && !w_rd_clr) begin
        r_ovr <= 1'b1;
      end

      if (w_wr_clr) begin
        r_ferr <= 1'b0;
      end else if (w_ferr_pulse) begin
        r_ferr <= 1'b1;
      end
    end
  end

`ifdef SERVANT_UART_RX_PARITY_EN
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_perr <= 1'b0;
    end else if (w_wr_clr) begin
      r_perr <= 1'b0;
    end else if (w_byte_stb && w_perr_pulse) begin
      r_perr <= 1'b1;
    end
  end
  assign w_perr_flag = r_perr;
`else
  assign w_perr_flag = 1'b0;
`endif

  assign o_wb_ack = r_ack;
  assign o_wb_rdt = r_rdt;

endmodule

// File: tb/tb_servant_uart_rx.sv
// tb_servant_uart_rx
// Scoreboard bench for servant_uart_rx with CLKS_PER_BIT = 16. Frames are
// driven on i_rx bit by bit; after each frame a small status model (byte,
// valid, ovr, ferr, perr) is updated from the frame contents. Every bus read
// pushes the modelled status word into a queue; a monitor pops and compares
// whenever the DUT acknowledges.
// Optional feature macro: SERVANT_UART_RX_PARITY_EN (parity frames/checks).
module tb_servant_uart_rx;

  localparam int C = 16;

  logic        wb_clk   = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        i_rx     = 1'b1;
  logic        i_wb_cyc = 1'b0;
  logic        i_wb_we  = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  always #5 wb_clk = ~wb_clk;

  servant_uart_rx #(
    .CLKS_PER_BIT (C)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .i_rx     (i_rx),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_we  (i_wb_we),
    .i_wb_dat (i_wb_dat),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack)
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] exp;
    logic [15:0] tag;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  int n_tests = 0;
  int n_fail  = 0;

  // Status model
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_perr  = 1'b0;

  function automatic logic [31:0] model_status();
    return {20'b0, m_perr, m_ferr, m_ovr, m_valid, m_data};
  endfunction

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
    m_perr  = 1'b0;
  endtask

  // Effect of one complete frame on the status word
  task automatic model_frame(input logic [7:0] b, input bit stop, input bit par);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
`ifdef SERVANT_UART_RX_PARITY_EN
      if ((($countones(b) + int'(par)) % 2) != 0) m_perr = 1'b1;
`else
      if (par) m_perr = m_perr;
`endif
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  // Monitor: compare every acknowledged read against the queued expectation
  always @(negedge wb_clk) begin
    if (wb_rst_n && o_wb_ack) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ack: rdt=0x%08h with no access pending", o_wb_rdt);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_read) begin
          n_tests++;
          if (o_wb_rdt !== mon_e.exp) begin
            n_fail++;
            $display("FAIL read_%0d: rdt=0x%08h expected 0x%08h", mon_e.tag, o_wb_rdt, mon_e.exp);
          end else begin
            $display("[TB] read_%0d rdt=0x%08h ok", mon_e.tag, o_wb_rdt);
          end
        end else begin
          $display("[TB] write_%0d acked", mon_e.tag);
        end
      end
    end
  end

  task automatic bus_access(input bit we, input int tag);
    sb_t e;
    @(negedge wb_clk);
    e.is_read = !we;
    e.exp     = model_status();
    e.tag     = tag[15:0];
    sb_q.push_back(e);
    if (we) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_perr = 1'b0;
    end else begin
      m_valid = 1'b0;
    end
    i_wb_cyc = 1'b1;
    i_wb_we  = we;
    i_wb_dat = $urandom;
    @(posedge wb_clk);
    #1;
    n_tests++;
    if (o_wb_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_%0d: ack=%b expected 1", tag, o_wb_ack);
    end
    @(negedge wb_clk);
    i_wb_cyc = 1'b0;
    i_wb_we  = 1'b0;
    repeat (2) @(negedge wb_clk);
  endtask

  // Drive one frame; abort_bit selects a data bit during which reset pulses
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit par,
                            input int abort_bit);
    i_rx = 1'b0;
    repeat (C) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      if (i == abort_bit) begin
        repeat (C / 2) @(negedge wb_clk);
        wb_rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        repeat (C - C / 2 - 3) @(negedge wb_clk);
      end else begin
        repeat (C) @(negedge wb_clk);
      end
    end
`ifdef SERVANT_UART_RX_PARITY_EN
    i_rx = par;
    repeat (C) @(negedge wb_clk);
`else
    if (par) i_rx = 1'b1;
`endif
    i_rx = stop;
    repeat (C) @(negedge wb_clk);
  endtask

  // Full frame plus line recovery and model update
  task automatic frame(input logic [7:0] b, input bit stop, input bit par,
                       input int hold_bits);
    send_frame(b, stop, par, -1);
    if (!stop) begin
      repeat (hold_bits * C) @(negedge wb_clk);
      i_rx = 1'b1;
    end
    repeat (2 * C) @(negedge wb_clk);
    model_frame(b, stop, par);
    $display("[TB] frame 0x%02h stop=%0d par=%0d sent", b, stop, par);
  endtask

  task automatic glitch(input int len);
    i_rx = 1'b0;
    repeat (len) @(negedge wb_clk);
    i_rx = 1'b1;
    repeat (2 * C) @(negedge wb_clk);
    $display("[TB] glitch of %0d cycles sent", len);
  endtask

  function automatic bit even_par(input logic [7:0] b);
    return ^b;
  endfunction

  initial begin
    int tag;
    int sel;
    logic [7:0] b;
    tag = 0;

    repeat (4) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    n_tests++;
    if (o_wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack: ack=%b expected 0", o_wb_ack);
    end
    n_tests++;
    if (o_wb_rdt !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdt: rdt=0x%08h expected 0x00000000", o_wb_rdt);
    end
    repeat (2 * C) @(negedge wb_clk);

    // Single byte, then read twice (valid clears)
    frame(8'hA5, 1'b1, even_par(8'hA5), 0);
    bus_access(1'b0, tag++);
    bus_access(1'b0, tag++);

    // Overrun: newest byte kept, write clears ovr
    frame(8'h31, 1'b1, even_par(8'h31), 0);
    frame(8'h32, 1'b1, even_par(8'h32), 0);
    bus_access(1'b0, tag++);
    bus_access(1'b1, tag++);
    bus_access(1'b0, tag++);

    // Framing error with a long break: a single ferr event
    frame(8'h55, 1'b0, even_par(8'h55), 40);
    bus_access(1'b0, tag++);
    bus_access(1'b1, tag++);

    // Short low pulse on an idle line is ignored
    glitch(4);
    bus_access(1'b0, tag++);

    // Reset during data bit 3, then a clean frame
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    repeat (2 * C) @(negedge wb_clk);
    frame(8'h12, 1'b1, even_par(8'h12), 0);
    bus_access(1'b0, tag++);

    // Randomized mix of frames, breaks, glitches and bus accesses
    for (int it = 0; it < 24; it++) begin
      sel = $urandom_range(0, 9);
      b   = 8'($urandom);
      if (sel <= 4)      frame(b, 1'b1, 1'($urandom), 0);
      else if (sel == 5) frame(b, 1'b0, 1'($urandom), $urandom_range(1, 5));
      else if (sel <= 7) bus_access(1'b0, tag++);
      else if (sel == 8) bus_access(1'b1, tag++);
      else               glitch($urandom_range(1, C / 2 - 2));
    end
    bus_access(1'b0, tag++);
    bus_access(1'b1, tag++);

`ifdef SERVANT_UART_RX_PARITY_EN
    frame(8'h03, 1'b1, 1'b1, 0);
    bus_access(1'b0, tag++);
    bus_access(1'b1, tag++);
    frame(8'h03, 1'b1, 1'b0, 0);
    bus_access(1'b0, tag++);
`endif

    repeat (4) @(negedge wb_clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
